// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave  : the loader (consumes bytes, drives the memory write port).
// master : the byte source / memory side (testbench or SoC glue).
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_WE;
  logic [ADDR_W-1:0] im_ADDR;
  logic [31:0]       im_DATA;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, im_WE, im_ADDR, im_DATA
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, im_WE, im_ADDR, im_DATA
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: packs an MSB-first byte stream into 32-bit
// words and writes them to consecutive instruction addresses. The CPU is held
// in reset (cpu_hold) during the load and for FLUSH_CYC cycles afterwards so
// both pipeline registers clear before release.
// Optional: IMEM_BOOT_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte
// (state CHK); on mismatch the CPU stays held until the next start or reset.
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int FLUSH_CYC = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  imem_boot_loader_if.slave bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HOLD  = 3'd1;
  localparam logic [2:0] RECV  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK   = 3'd5;
  localparam logic [2:0] AFTER_LOAD = CHK;
`else
  localparam logic [2:0] AFTER_LOAD = FLUSH;
`endif

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam int              FCW     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCW-1:0]  FL_LAST = FCW'(FLUSH_CYC - 1);

  logic [2:0]        state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   widx;
  logic [1:0]        bcnt;
  logic [23:0]       word_hi;   // first three bytes of the word in progress
  logic [FCW-1:0]    flush_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              xfer;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Status and handshake decode straight from registered state
  assign busy           = (state != IDLE);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  assign bus.byte_ready = (state == RECV) || (state == CHK);
`else
  assign bus.byte_ready = (state == RECV);
`endif
  assign xfer           = bus.byte_valid && bus.byte_ready;
  // Abort in WRITE suppresses the strobe in the same cycle
  assign bus.im_WE      = (state == WRITE) && !abort;
  assign bus.im_ADDR    = addr_q;
  assign bus.im_DATA    = data_q;

  // Load sequencer: byte packing, word writes, hold/flush and status flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      len       <= '0;
      widx      <= '0;
      bcnt      <= '0;
      word_hi   <= '0;
      flush_cnt <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state != FLUSH) flush_cnt <= '0;
      case (state)
        IDLE: begin
          // start wins over a simultaneous abort
          if (start) begin
            len      <= load_len;
            err      <= 1'b0;
            widx     <= '0;
            bcnt     <= '0;
            cpu_hold <= 1'b1;
            state    <= HOLD;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        HOLD: begin
          if (abort) begin
            err   <= 1'b1;
            state <= FLUSH;
          end else begin
            // Oversized lengths are clamped so the address can never wrap
            if (len > MAX_LEN) begin
              len <= MAX_LEN;
              err <= 1'b1;
            end
            state <= (len == '0) ? AFTER_LOAD : RECV;
          end
        end
        RECV: begin
          if (abort) begin
            err   <= 1'b1;
            bcnt  <= '0;
            state <= FLUSH;
          end else if (xfer) begin
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum <= csum + bus.byte_in;
`endif
            case (bcnt)
              2'd0: word_hi[23:16] <= bus.byte_in;
              2'd1: word_hi[15:8]  <= bus.byte_in;
              2'd2: word_hi[7:0]   <= bus.byte_in;
              default: begin
                data_q <= {word_hi, bus.byte_in};
                addr_q <= widx[ADDR_W-1:0];
                state  <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if (abort) begin
            err   <= 1'b1;
            state <= FLUSH;
          end else begin
            widx  <= widx + (ADDR_W+1)'(1);
            bcnt  <= '0;
            state <= (widx + (ADDR_W+1)'(1) == len) ? AFTER_LOAD : RECV;
          end
        end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        CHK: begin
          if (abort) begin
            err   <= 1'b1;
            state <= FLUSH;
          end else if (xfer) begin
            if (bus.byte_in == csum) begin
              state <= FLUSH;
            end else begin
              // Bad image: report and park with the CPU still held
              err   <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
`endif
        FLUSH: begin
          if (flush_cnt == FL_LAST) begin
            cpu_hold <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + FCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Instruction-memory programmer that drives the processor's instruction-memory load port (im_WE / im_DATA), the write side of that interface.
- Accepts a byte stream over a valid/ready handshake and packs the bytes MSB-first into 32-bit words.
- Writes each word to sequential instruction addresses.
- Holds the processor (PC and pipeline registers) in reset while loading, then flushes and releases it.

Parameters:
- ADDR_W, 8: instruction address width; max program = 2^ADDR_W words.
- FLUSH_CYC, 2: cycles cpu_hold stays high after the last write, so both pipeline registers clear.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  terminate the load in progress.
- load_len  in  ADDR_W+1  number of words to load; sampled with start.
- byte_in  in  8  stream data.
- byte_valid  in  1  stream data valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- im_WE  out  1  instruction-memory write strobe, one cycle per word.
- im_ADDR  out  ADDR_W  word address of the current write.
- im_DATA  out  32  assembled word.
- cpu_hold  out  1  drives pc_RESET and both pipeline-register RESETs.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the load completes or aborts.
- err  out  1  sticky error flag, cleared by the next accepted start.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; word count, byte count and address counters 0.
- IDLE:
  - On start=1: latch load_len, clear err, counters to 0, assert cpu_hold, go to HOLD.
  - start=0: stay in IDLE.
- HOLD (1 cycle), sets cpu_hold=1:
  - load_len==0 → FLUSH (no writes).
  - otherwise → RECV.
- RECV:
  - byte_ready=1. A byte transfers when byte_valid && byte_ready.
  - Byte k of the word (k=0..3) goes to bits [31-8k -: 8].
  - After the 4th byte go to WRITE; byte_ready is 0 from that cycle.
- WRITE (1 cycle):
  - im_WE=1; im_ADDR = word index; im_DATA = assembled word.
  - Next cycle: word index +1, byte count 0.
  - If word index+1 == load_len → FLUSH, else → RECV.
- FLUSH:
  - cpu_hold stays 1 for FLUSH_CYC cycles; then cpu_hold=0, done=1 for one cycle, go to IDLE.
- Outputs outside WRITE: im_WE=0; im_DATA and im_ADDR hold their last values.
- Throughput: minimum 5 cycles per word (4 byte transfers + 1 write).
- byte_valid low: no progress; partial bytes are retained indefinitely.
- load_len > 2^ADDR_W: clamp to 2^ADDR_W; set err=1 at HOLD; loading proceeds.
- Address wrap: cannot occur, because the length is clamped.
- abort:
  - In HOLD, RECV or WRITE: highest priority. No write happens that cycle, err=1, go to FLUSH.
  - Partial word discarded; words already written remain in memory.
  - In FLUSH or IDLE: ignored.
- start while busy: ignored.
- start and abort together in IDLE: the start is taken.
- RESET mid-load: immediate return to IDLE, cpu_hold=0. Any partial word is lost.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all accepted data bytes is kept.
  - After the last WRITE, state CHK accepts one more byte (byte_ready=1).
  - Match → FLUSH as normal.
  - Mismatch → err=1, done pulse, go to IDLE with cpu_hold left at 1; the processor is not released until the next start or RESET.
  - load_len==0: checksum expected 0x00.
- Undefined: no CHK state; no checksum byte is consumed.

Test Plan:
- Basic load: start with load_len=2, bytes 01 02 03 04 AA BB CC DD sent back-to-back → im_WE pulses at addr 0 (0x01020304) and addr 1 (0xAABBCCDD); cpu_hold falls FLUSH_CYC=2 cycles after the second write; done pulses once; err=0.
- Stalled source: same stream with byte_valid toggled 1/0 every cycle → identical writes; byte_ready=0 during WRITE; no byte lost or duplicated.
- Zero length: load_len=0 → no im_WE; cpu_hold high for HOLD+2 cycles; done pulses; err=0.
- Abort: load_len=3, abort after 6 bytes → exactly one write (addr 0); err=1; cpu_hold released after flush; start with load_len=1 and bytes 00 00 00 13 → err clears and addr 0 is written with 0x00000013.
- Async reset: RESET asserted mid-RECV between clock edges → cpu_hold, byte_ready and busy go to 0 immediately; a following start loads from addr 0.
- Checksum (macro defined): bytes 01 02 03 04 then checksum 0x0A → normal release; checksum 0x0B → err=1, done pulses, cpu_hold stays 1.
